// File: rtl/pipe_stage_skid_reg.sv
// Flow-controlled pipeline stage with a 2-entry skid buffer.
//
// A main entry drives the outputs; a skid entry catches the one payload that
// can arrive while the consumer is stalled. in_ready depends only on registered
// state, so no combinational ready path crosses the stage. Bubbles present an
// all-zero control payload so downstream write enables stay inert. out_data is
// left at its last value across bubbles to avoid toggling.
//
// Ports:
//   Clk, Reset           rising-edge clock, asynchronous active-high reset
//   Flush                synchronous flush, empties the stage
//   in_valid/in_ready    upstream handshake
//   in_ctrl/in_data      upstream payload
//   out_valid/out_ready  downstream handshake
//   out_ctrl/out_data    downstream payload (out_ctrl is zero when out_valid=0)
//   stall_count          saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic pop;

  // Valid bits of both entries are encoded by the state.
  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);

  assign in_ready    = ~skid_valid;
  assign out_valid   = main_valid;
  assign out_ctrl    = main_valid ? main_ctrl_q : '0;
  assign out_data    = main_data_q;
  assign stall_count = stall_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = StFull;
        end else if (pop) begin
          main_ctrl_d = '0;
          state_d     = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
          state_d     = StOne;
        end
      end
      default: begin
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
        state_d     = StEmpty;
      end
    endcase

    // Flush wins over any transfer: a same-cycle accept is dropped, and the
    // data register keeps its last presented value rather than the dropped one.
    if (Flush) begin
      state_d     = StEmpty;
      main_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_ctrl_d = '0;
    end
  end

  // Stall counter ignores Flush; only Reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule
